// File: rtl/full_adder_pkg.sv
// Shared arithmetic definitions for the adder cells: default slice count and
// the 1-bit full-adder equations.
package full_adder_pkg;

    localparam int ADDER_W = 1;

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (a & cin) | (b & cin);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder: {cout, sum} = a + b + cin.
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH independent full adders (3:2 carry-save compressor) with an optional
// output register. Slices share no carry; chaining is left to the parent.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = ADDER_W,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout
);

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] cout_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (cin[i]),
            .sum  (sum_c[i]),
            .cout (cout_c[i])
        );
    end

    // Handshake: valid-only. A result is taken when in_valid is high at the
    // capture point; out_valid marks the cycle it is presented. No ready.
    if (REG_OUT) begin : g_reg
        // sum/cout hold while idle; consumers ignore them when out_valid is 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid <= 1'b0;
                sum       <= '0;
                cout      <= '0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum  <= sum_c;
                    cout <= cout_c;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign out_valid      = in_valid;
        assign sum            = sum_c;
        assign cout           = cout_c;
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: combinational 1-bit cell, registered 8-bit stage with
// reset, and a 4-bit ripple chain built from 1-bit instances.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // combinational WIDTH=1 instance
    logic       c_in_valid, c_out_valid;
    logic [0:0] c_a, c_b, c_cin, c_sum, c_cout;
    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid),
        .a(c_a), .b(c_b), .cin(c_cin),
        .out_valid(c_out_valid), .sum(c_sum), .cout(c_cout)
    );

    // registered WIDTH=8 instance
    logic       r_in_valid, r_out_valid;
    logic [7:0] r_a, r_b, r_cin, r_sum, r_cout;
    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid),
        .a(r_a), .b(r_b), .cin(r_cin),
        .out_valid(r_out_valid), .sum(r_sum), .cout(r_cout)
    );

    // 4-bit ripple adder from chained 1-bit combinational cells
    logic [3:0] rp_a, rp_b, rp_sum, rp_ov;
    logic       rp_cin;
    logic [4:0] rp_carry;
    assign rp_carry[0] = rp_cin;
    for (genvar k = 0; k < 4; k++) begin : g_rp
        full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_rp (
            .clk(clk), .rst_n(rst_n), .in_valid(1'b1),
            .a(rp_a[k]), .b(rp_b[k]), .cin(rp_carry[k]),
            .out_valid(rp_ov[k]), .sum(rp_sum[k]), .cout(rp_carry[k+1])
        );
    end

    logic [1:0]  exp1_q[$];   // {cout, sum}
    logic [15:0] exp8_q[$];   // {cout, sum}

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (c_out_valid === 1'b1) begin
            if (exp1_q.size() == 0) check("comb_unexpected_valid", 16'd1, 16'd0);
            else check("comb_result", {14'd0, c_cout, c_sum}, {14'd0, exp1_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && r_out_valid === 1'b1) begin
            if (exp8_q.size() == 0) check("reg_unexpected_valid", 16'd1, 16'd0);
            else check("reg_result", {r_cout, r_sum}, exp8_q.pop_front());
        end
    end

    // driver tasks
    task automatic drive_comb(input logic a, input logic b, input logic c, input logic [1:0] exp);
        @(posedge clk); #1;
        c_a = a; c_b = b; c_cin = c; c_in_valid = 1'b1;
        exp1_q.push_back(exp);
    endtask

    task automatic drive_reg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] exp_sum, input logic [7:0] exp_cout);
        @(posedge clk); #1;
        r_a = a; r_b = b; r_cin = c; r_in_valid = 1'b1;
        exp8_q.push_back({exp_cout, exp_sum});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            r_in_valid = 1'b0;
        end
    endtask

    task automatic ripple(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] exp);
        rp_a = a; rp_b = b; rp_cin = c;
        #1;
        check("ripple_sum", {11'd0, rp_carry[4], rp_sum}, {11'd0, exp});
    endtask

    // {cout, sum} for abc = 000..111
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst_n = 1'b0;
        c_in_valid = 1'b0; c_a = '0; c_b = '0; c_cin = '0;
        r_in_valid = 1'b0; r_a = '0; r_b = '0; r_cin = '0;
        rp_a = '0; rp_b = '0; rp_cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {r_out_valid, r_cout, r_sum[6:0]}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            drive_comb(idx[2], idx[1], idx[0], tt[i]);
        end
        idle(1);

        drive_reg(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00);
        idle(2);
        drive_reg(8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF);
        drive_reg(8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF);
        idle(2);

        // three back-to-back transfers
        drive_reg(8'h0F, 8'h33, 8'h55, 8'h69, 8'h17);
        drive_reg(8'h12, 8'h34, 8'h56, 8'h70, 8'h16);
        drive_reg(8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'hC3);
        idle(3);

        // asynchronous reset mid-stream, with a second result in flight
        drive_reg(8'hFF, 8'hAA, 8'hFF, 8'hAA, 8'hFF);
        drive_reg(8'h12, 8'h34, 8'h56, 8'h70, 8'h16);
        @(negedge clk); #2;
        rst_n = 1'b0;
        r_in_valid = 1'b0;
        exp8_q.delete();
        #1;
        check("async_reset_outputs", {r_cout, r_sum}, 16'd0);
        check("async_reset_valid", {15'd0, r_out_valid}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_hold", {r_out_valid, r_cout, r_sum[6:0]}, 16'd0);
        end
        drive_reg(8'h0F, 8'h33, 8'h55, 8'h69, 8'h17);
        idle(2);

        ripple(4'hB, 4'h6, 1'b1, 5'd18);
        ripple(4'hF, 4'hF, 1'b1, 5'd31);
        ripple(4'h0, 4'h0, 1'b0, 5'd0);
        ripple(4'h9, 4'h7, 1'b0, 5'd16);

        for (int t = 0; t < 20 && (exp1_q.size() != 0 || exp8_q.size() != 0); t++) @(posedge clk);
        check("drain_comb", 16'(exp1_q.size()), 16'd0);
        check("drain_reg", 16'(exp8_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
